// File: rtl/uart_wb_burst_bridge_pkg.sv
// Shared definitions for the UART-to-Wishbone burst bridge: command codes,
// FSM state encoding and byte-per-word helpers.
package uart_wb_burst_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_ADDR,
    S_WDATA,
    S_WB_WR,
    S_WB_RD,
    S_TX
  } state_t;

  function automatic int bpw_of(input int dw);
    return dw / 8;
  endfunction

  // The shifter must hold a full 32-bit address even when words are narrower.
  function automatic int shift_w(input int dw);
    return (dw > 32) ? dw : 32;
  endfunction

endpackage

// File: rtl/uart_wb_burst_shift.sv
// Byte-wide MSB-first shift register with byte counter; collects address and
// write-data bytes and serialises read words towards the transmitter.
module uart_wb_burst_shift #(
  parameter int SW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          shift_i,
  input  logic          load_i,
  input  logic [7:0]    byte_i,
  input  logic [SW-1:0] load_data_i,
  output logic [SW-1:0] word_o,
  output logic [3:0]    cnt_o
);

  logic [SW-1:0] word_q;
  logic [3:0]    cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      word_q <= load_data_i;
      cnt_q  <= '0;
    end else begin
      if (shift_i) word_q <= {word_q[SW-9:0], byte_i};
      if (clr_i)
        cnt_q <= '0;
      else if (shift_i)
        cnt_q <= cnt_q + 4'd1;
    end
  end

  assign word_o = word_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/uart_wb_burst_bridge.sv
// Byte-stream to Wishbone master bridge: decodes CMD/LEN/ADDR frames and runs
// single-beat write or read bursts with address auto-increment.
module uart_wb_burst_bridge
  import uart_wb_burst_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 30,
  parameter int ADDR_INCR      = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [ADDR_WIDTH-1:0]   wb_adr,
  output logic [DATA_WIDTH-1:0]   wb_dat_w,
  input  logic [DATA_WIDTH-1:0]   wb_dat_r,
  output logic [DATA_WIDTH/8-1:0] wb_sel,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic                    wb_we,
  input  logic                    wb_ack,
  input  logic                    wb_err,
  output logic                    busy,
  output logic                    err_sticky
);

  localparam int BPW = bpw_of(DATA_WIDTH);
  localparam int SW  = shift_w(DATA_WIDTH);
  localparam logic [3:0]            LAST_W  = 4'(BPW - 1);
  localparam logic [31:0]           TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] INCR    = ADDR_WIDTH'(ADDR_INCR);

  state_t                  state_q;
  logic [8:0]              len_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_w_q;
  logic                    cyc_q;
  logic                    we_q;
  logic                    err_q;
  logic                    is_rd_q;
  logic [31:0]             tout_q;

  logic                    rx_state;
  logic                    rx_fire;
  logic                    term;
  logic                    last_beat;
  logic                    sh_shift;
  logic                    sh_clr;
  logic                    sh_load;
  logic [7:0]              sh_byte;
  logic [SW-1:0]           sh_ld_data;
  logic [SW-1:0]           sh_word;
  logic [SW-1:0]           word_d;
  logic [3:0]              sh_cnt;

  assign rx_state  = (state_q == S_IDLE) || (state_q == S_LEN) ||
                     (state_q == S_ADDR) || (state_q == S_WDATA);
  assign rx_ready  = rx_state && !rst;
  assign rx_fire   = rx_valid && rx_ready;
  assign term      = cyc_q && (wb_ack || wb_err);
  assign last_beat = (len_q == 9'd1);
  assign sh_byte   = rx_state ? rx_data : 8'h00;
  // Word as it looks once the byte arriving this cycle is shifted in.
  assign word_d    = {sh_word[SW-9:0], rx_data};

  always_comb begin
    sh_shift   = 1'b0;
    sh_clr     = 1'b0;
    sh_load    = 1'b0;
    sh_ld_data = '0;
    case (state_q)
      S_LEN:   sh_clr = 1'b1;
      S_ADDR: begin
        sh_shift = rx_fire;
        sh_clr   = rx_fire && (sh_cnt == 4'd3);
      end
      S_WDATA: begin
        sh_shift = rx_fire;
        sh_clr   = rx_fire && (sh_cnt == LAST_W);
      end
      S_WB_RD: begin
        sh_load    = term;
        sh_ld_data = wb_err ? '0 : SW'(wb_dat_r);
      end
      S_TX: begin
        sh_shift = tx_ready;
        sh_clr   = tx_ready && (sh_cnt == LAST_W);
      end
      default: ;
    endcase
  end

  uart_wb_burst_shift #(.SW(SW)) u_shift (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (sh_clr),
    .shift_i     (sh_shift),
    .load_i      (sh_load),
    .byte_i      (sh_byte),
    .load_data_i (sh_ld_data),
    .word_o      (sh_word),
    .cnt_o       (sh_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      adr_q   <= '0;
      dat_w_q <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      is_rd_q <= 1'b0;
      tout_q  <= '0;
    end else begin
      if (!rx_state || rx_fire || state_q == S_IDLE)
        tout_q <= '0;
      else
        tout_q <= tout_q + 32'd1;

      case (state_q)
        S_IDLE: begin
          if (rx_fire && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
            is_rd_q <= (rx_data == CMD_READ);
            state_q <= S_LEN;
          end
        end
        S_LEN: begin
          if (rx_fire) begin
            len_q   <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (rx_fire && sh_cnt == 4'd3) begin
            adr_q <= ADDR_WIDTH'(word_d[31:0]);
            if (is_rd_q) begin
              cyc_q   <= 1'b1;
              we_q    <= 1'b0;
              state_q <= S_WB_RD;
            end else begin
              state_q <= S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (rx_fire && sh_cnt == LAST_W) begin
            dat_w_q <= word_d[DATA_WIDTH-1:0];
            cyc_q   <= 1'b1;
            we_q    <= 1'b1;
            state_q <= S_WB_WR;
          end
        end
        S_WB_WR: begin
          if (term) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= err_q | wb_err;
            len_q   <= len_q - 9'd1;
            adr_q   <= adr_q + INCR;
            state_q <= last_beat ? S_IDLE : S_WDATA;
          end
        end
        S_WB_RD: begin
          if (term) begin
            cyc_q   <= 1'b0;
            err_q   <= err_q | wb_err;
            state_q <= S_TX;
          end
        end
        S_TX: begin
          if (tx_ready && sh_cnt == LAST_W) begin
            len_q <= len_q - 9'd1;
            adr_q <= adr_q + INCR;
            if (last_beat) begin
              state_q <= S_IDLE;
            end else begin
              cyc_q   <= 1'b1;
              state_q <= S_WB_RD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // An idle host mid-frame abandons the partial frame; no bus cycle starts.
      if (TIMEOUT_CYCLES != 0 && rx_state && state_q != S_IDLE &&
          !rx_fire && tout_q == TO_LAST) begin
        state_q <= S_IDLE;
        err_q   <= 1'b1;
      end
    end
  end

  assign wb_adr     = adr_q;
  assign wb_dat_w   = dat_w_q;
  assign wb_we      = we_q;
  assign wb_cyc     = cyc_q;
  assign wb_stb     = cyc_q;
  assign wb_sel     = {BPW{cyc_q}};
  assign tx_valid   = (state_q == S_TX);
  assign tx_data    = sh_word[DATA_WIDTH-1 -: 8];
  assign busy       = (state_q != S_IDLE);
  assign err_sticky = err_q;

endmodule
